// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the XALU multiply/divide unit.
//   md_op_t          - operation code presented to xalu_md on 'op'
//   md_state_t       - IDLE/RUN sequencing state of xalu_md
//   md_encode_funct  - maps an R-type IR funct field to md_op_t so that the
//                      control decoder and the unit agree on encodings
//   md_is_long       - 1 for the multi-cycle ops (MULT/MULTU/DIV/DIVU)
package md_pkg;

    localparam int MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // R-type funct codes handled by the unit; anything else is not an XALU op.
    function automatic md_op_t md_encode_funct(input logic [5:0] funct);
        md_op_t enc;
        case (funct)
            6'h18:   enc = MD_MULT;
            6'h19:   enc = MD_MULTU;
            6'h1A:   enc = MD_DIV;
            6'h1B:   enc = MD_DIVU;
            6'h11:   enc = MD_MTHI;
            6'h13:   enc = MD_MTLO;
            default: enc = MD_NONE;
        endcase
        return enc;
    endfunction

    function automatic logic md_is_long(input md_op_t op);
        logic res;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/md_core.sv
// md_core: purely combinational result generator for xalu_md.
//   op      in  MD_OP_W  operation (md_op_t encoding)
//   a, b    in  WIDTH    operands (rs, rt)
//   hi, lo  in  WIDTH    committed HI/LO, returned unchanged where an op keeps them
//   res_hi  out WIDTH    HI value the op produces
//   res_lo  out WIDTH    LO value the op produces
// Signed division works on magnitudes and restores signs afterwards: the
// quotient is negative when operand signs differ (truncation toward zero),
// the remainder follows the dividend. MIN / -1 falls out naturally as
// quotient MIN, remainder 0, because |MIN| is representable as unsigned.
module md_core
    import md_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIVZ_HOLD = 1
) (
    input  logic [MD_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo
);

    localparam int  PW      = 2 * WIDTH;
    localparam bit  HOLD_ON = (DIVZ_HOLD != 32'sd0);

    logic [PW-1:0]    a_sx_s, b_sx_s, a_zx_s, b_zx_s;
    logic [PW-1:0]    prod_sgn_s, prod_uns_s;
    logic             a_neg_s, b_neg_s, b_zero_s;
    logic [WIDTH-1:0] one_s;
    logic [WIDTH-1:0] b_safe_s, uq_s, ur_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s, b_mag_safe_s;
    logic [WIDTH-1:0] sq_mag_s, sr_mag_s, sq_s, sr_s;
    logic [WIDTH-1:0] divz_hi_s, divz_lo_s;

    assign one_s = {{(WIDTH-1){1'b0}}, 1'b1};

    // Low 2*WIDTH bits of the product of sign-extended operands equal the
    // exact signed product, so one unsigned multiplier shape serves both.
    assign a_sx_s     = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx_s     = {{WIDTH{b[WIDTH-1]}}, b};
    assign a_zx_s     = {{WIDTH{1'b0}}, a};
    assign b_zx_s     = {{WIDTH{1'b0}}, b};
    assign prod_sgn_s = a_sx_s * b_sx_s;
    assign prod_uns_s = a_zx_s * b_zx_s;

    // Divisor forced to 1 when zero so the divider never sees x/0; the
    // zero-divisor result is selected separately below.
    assign b_zero_s = (b == {WIDTH{1'b0}});
    assign b_safe_s = b_zero_s ? one_s : b;
    assign uq_s     = a / b_safe_s;
    assign ur_s     = a % b_safe_s;

    assign a_neg_s      = a[WIDTH-1];
    assign b_neg_s      = b[WIDTH-1];
    assign a_mag_s      = a_neg_s ? ({WIDTH{1'b0}} - a) : a;
    assign b_mag_s      = b_neg_s ? ({WIDTH{1'b0}} - b) : b;
    assign b_mag_safe_s = b_zero_s ? one_s : b_mag_s;
    assign sq_mag_s     = a_mag_s / b_mag_safe_s;
    assign sr_mag_s     = a_mag_s % b_mag_safe_s;
    assign sq_s         = (a_neg_s ^ b_neg_s) ? ({WIDTH{1'b0}} - sq_mag_s) : sq_mag_s;
    assign sr_s         = a_neg_s ? ({WIDTH{1'b0}} - sr_mag_s) : sr_mag_s;

    assign divz_hi_s = HOLD_ON ? hi : a;
    assign divz_lo_s = HOLD_ON ? lo : {WIDTH{1'b1}};

    // Result select per operation; non-arithmetic ops keep HI/LO.
    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (md_op_t'(op))
            MD_MULT: begin
                res_hi = prod_sgn_s[PW-1:WIDTH];
                res_lo = prod_sgn_s[WIDTH-1:0];
            end
            MD_MULTU: begin
                res_hi = prod_uns_s[PW-1:WIDTH];
                res_lo = prod_uns_s[WIDTH-1:0];
            end
            MD_DIV: begin
                if (b_zero_s) begin
                    res_hi = divz_hi_s;
                    res_lo = divz_lo_s;
                end else begin
                    res_hi = sr_s;
                    res_lo = sq_s;
                end
            end
            MD_DIVU: begin
                if (b_zero_s) begin
                    res_hi = divz_hi_s;
                    res_lo = divz_lo_s;
                end else begin
                    res_hi = ur_s;
                    res_lo = uq_s;
                end
            end
            default: begin
                res_hi = hi;
                res_lo = lo;
            end
        endcase
    end

endmodule

// File: rtl/xalu_md.sv
// xalu_md: E-stage multiply/divide unit with HI/LO registers.
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high; aborts any op in flight
//   start     in   1      issue 'op' this cycle
//   op        in   3      md_op_t
//   a, b      in   WIDTH  forwarded rs / rt values
//   rd_hi     in   1      selects HI (1) or LO (0) onto xalu_out
//   busy      out  1      registered, high while a MULT/DIV is in flight
//   done      out  1      registered one-cycle pulse when HI/LO commit
//   hi, lo    out  WIDTH  committed HI / LO
//   xalu_out  out  WIDTH  HI or LO for MFHI/MFLO
// The result is computed at issue and parked in pend_*; it only becomes
// visible in hi/lo after the modelled latency, so MFHI/MFLO never observe a
// result earlier than the real multi-cycle hardware would produce it.
module xalu_md
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int DIVZ_HOLD   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               rd_hi,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   xalu_out
);

    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] pend_hi_r, pend_lo_r;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             busy_r, done_r;

    md_op_t           op_s;
    logic             issue_long_s, issue_mthi_s, issue_mtlo_s;
    logic [CNT_W-1:0] load_cnt_s;
    logic [WIDTH-1:0] res_hi_s, res_lo_s;

    assign op_s = md_op_t'(op);

    md_core #(
        .WIDTH     (WIDTH),
        .DIVZ_HOLD (DIVZ_HOLD)
    ) u_core (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (hi_r),
        .lo     (lo_r),
        .res_hi (res_hi_s),
        .res_lo (res_lo_s)
    );

    // Issue decode: only accepted in IDLE, so a start while busy is dropped.
    always_comb begin
        issue_long_s = 1'b0;
        issue_mthi_s = 1'b0;
        issue_mtlo_s = 1'b0;
        load_cnt_s   = MULT_LOAD;
        if (start && (state_r == ST_IDLE)) begin
            case (op_s)
                MD_MULT, MD_MULTU: begin
                    issue_long_s = 1'b1;
                    load_cnt_s   = MULT_LOAD;
                end
                MD_DIV, MD_DIVU: begin
                    issue_long_s = 1'b1;
                    load_cnt_s   = DIV_LOAD;
                end
                MD_MTHI: issue_mthi_s = 1'b1;
                MD_MTLO: issue_mtlo_s = 1'b1;
                default: begin
                    issue_long_s = 1'b0;
                end
            endcase
        end else begin
            issue_long_s = 1'b0;
        end
    end

    // Sequencer: latency counter, pending result and HI/LO commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            pend_hi_r <= {WIDTH{1'b0}};
            pend_lo_r <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (issue_long_s) begin
                        pend_hi_r <= res_hi_s;
                        pend_lo_r <= res_lo_s;
                        cnt_r     <= load_cnt_s;
                        busy_r    <= 1'b1;
                        state_r   <= ST_RUN;
                    end else if (issue_mthi_s) begin
                        hi_r <= a;
                    end else if (issue_mtlo_s) begin
                        lo_r <= a;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        hi_r    <= pend_hi_r;
                        lo_r    <= pend_lo_r;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign xalu_out = rd_hi ? hi_r : lo_r;

endmodule
